// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, fetch state encoding and constants for the MIPS pipeline
package pipeline_pkg;
  localparam int INST_W = 32;
  localparam int BYTES_PER_INST = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  typedef enum logic {FETCH, HOLD} fetch_state_e;
endpackage

// File: rtl/inst_byte_assembler.sv
// inst_byte_assembler: byte counter and big-endian assembly register for one instruction
module inst_byte_assembler
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              lat_i,
  input  logic              step_i,
  input  logic [7:0]        data_i,
  output logic [1:0]        idx_o,
  output logic              complete_o,
  output logic [INST_W-1:0] asm_o
);
  logic [1:0]        idx_q;
  logic [INST_W-1:0] asm_q, asm_d;
  always_comb begin
    asm_d = asm_q;
    asm_d[{~idx_q, 3'b000} +: 8] = data_i;
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      if (lat_i) asm_q <= asm_d;
      if (step_i) idx_q <= idx_q + 2'd1;
    end
  end
  assign idx_o = idx_q;
  assign complete_o = idx_q == 2'd3;
  assign asm_o = asm_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: byte-serial instruction fetch with PC, redirect and a one-entry output buffer.
// Define INST_FETCH_MISALIGN_CHK_EN to add the misalign_err pulse output.
module inst_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int             PCL      = 32,
  parameter int             WORD     = 8,
  parameter logic [PCL-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PCL-1:0]    mem_addr,
  input  logic [WORD-1:0]   mem_data,
  input  logic              redirect,
  input  logic [PCL-1:0]    redirect_pc,
  output logic [INST_W-1:0] inst_out,
  output logic [PCL-1:0]    pc_out,
  output logic [PCL-1:0]    pc_plus4,
  output logic              inst_valid,
`ifdef INST_FETCH_MISALIGN_CHK_EN
  output logic              misalign_err,
`endif
  input  logic              inst_ready
);
  if (WORD != 8) begin : g_bad_word
    $error("inst_fetch_unit supports only WORD == 8");
  end
  fetch_state_e      state_q;
  logic [PCL-1:0]    fetch_pc_q, pc_q;
  logic [INST_W-1:0] inst_q, asm, word;
  logic [1:0]        idx;
  logic              valid_q, complete, buf_empty, load;
  assign buf_empty = !valid_q || inst_ready;
  assign load = complete && buf_empty;
  inst_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .lat_i      (state_q == FETCH),
    .step_i     (!complete || buf_empty),
    .data_i     (mem_data[7:0]),
    .idx_o      (idx),
    .complete_o (complete),
    .asm_o      (asm)
  );
  // in HOLD the low byte is already in the register; in FETCH it is still on the bus
  assign word = {asm[31:8], state_q == HOLD ? asm[7:0] : mem_data[7:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      state_q <= FETCH;
      valid_q <= 1'b0;
      inst_q <= '0;
      pc_q <= '0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc & ~PCL'(3);
      state_q <= FETCH;
      valid_q <= 1'b0;
    end else begin
      state_q <= (complete && !buf_empty) ? HOLD : FETCH;
      valid_q <= load || (valid_q && !inst_ready);
      if (load) begin
        inst_q <= word;
        pc_q <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + PCL'(BYTES_PER_INST);
      end
    end
  end
`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  always_ff @(posedge clk) misalign_q <= rst ? 1'b0 : redirect && |redirect_pc[1:0];
  assign misalign_err = misalign_q;
`endif
  assign mem_addr = fetch_pc_q + PCL'(idx);
  assign inst_out = inst_q;
  assign pc_out = pc_q;
  assign pc_plus4 = pc_q + PCL'(BYTES_PER_INST);
  assign inst_valid = valid_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch latency, stall/HOLD, redirect, reset and PC wrap
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1, rst1 = 1'b1;
  logic        redirect = 1'b0, ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic [31:0] addr0, addr1, inst0, inst1, pc0, pc1, p40, p41;
  logic [7:0]  data0, data1;
  logic        valid0, valid1;
  logic [7:0]  mem [256];
  int          errs = 0, checks = 0;
  always #5 clk = ~clk;
  assign data0 = mem[addr0[7:0]];
  assign data1 = mem[addr1[7:0]];
`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic mis0, mis1;
`endif
  inst_fetch_unit dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr0), .mem_data(data0),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_out(inst0), .pc_out(pc0), .pc_plus4(p40), .inst_valid(valid0),
`ifdef INST_FETCH_MISALIGN_CHK_EN
    .misalign_err(mis0),
`endif
    .inst_ready(ready)
  );
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst1), .mem_addr(addr1), .mem_data(data1),
    .redirect(1'b0), .redirect_pc(32'h0),
    .inst_out(inst1), .pc_out(pc1), .pc_plus4(p41), .inst_valid(valid1),
`ifdef INST_FETCH_MISALIGN_CHK_EN
    .misalign_err(mis1),
`endif
    .inst_ready(1'b1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]} = 32'h8C01_0004;
    {mem[4], mem[5], mem[6], mem[7]} = 32'hAC02_0008;
    {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} = 32'h1234_5678;
    {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]} = 32'hDEAD_BEEF;
    tick();
    // wrap instance: fetch from FC..FF, then continue at 0
    rst1 = 1'b0;
    chk("wrap_rst_addr", addr1, 32'hFFFF_FFFC);
    chk("wrap_rst_p4", p41, 32'd4);
    tick(3);
    chk("wrap_addr_ff", addr1, 32'hFFFF_FFFF);
    chk("wrap_not_yet", {31'd0, valid1}, 32'd0);
    tick();
    chk("wrap_valid", {31'd0, valid1}, 32'd1);
    chk("wrap_inst", inst1, 32'hDEAD_BEEF);
    chk("wrap_pc", pc1, 32'hFFFF_FFFC);
    chk("wrap_p4", p41, 32'h0);
    chk("wrap_addr0", addr1, 32'h0);
    // main instance reset state
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_inst", inst0, 32'h0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_p4", p40, 32'd4);
    chk("rst_addr", addr0, 32'h0);
    rst = 1'b0;
    tick(3);
    chk("lat_not_yet", {31'd0, valid0}, 32'd0);
    chk("lat_addr3", addr0, 32'd3);
    tick();
    chk("first_valid", {31'd0, valid0}, 32'd1);
    chk("first_inst", inst0, 32'h8C01_0004);
    chk("first_pc", pc0, 32'h0);
    chk("first_p4", p40, 32'd4);
    // downstream stall: output held, fetch runs on into HOLD
    ready = 1'b0;
    tick(12);
    chk("stall_valid", {31'd0, valid0}, 32'd1);
    chk("stall_inst", inst0, 32'h8C01_0004);
    chk("stall_pc", pc0, 32'h0);
    chk("hold_addr", addr0, 32'd7);
    ready = 1'b1;
    tick();
    chk("release_inst", inst0, 32'hAC02_0008);
    chk("release_pc", pc0, 32'd4);
    chk("release_valid", {31'd0, valid0}, 32'd1);
    chk("release_addr", addr0, 32'd8);
    // redirect mid-instruction (byte_idx == 2)
    tick(2);
    chk("pre_redir_addr", addr0, 32'hA);
    redirect = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, valid0}, 32'd0);
    chk("redir_addr", addr0, 32'h20);
`ifdef INST_FETCH_MISALIGN_CHK_EN
    chk("aligned_no_err", {31'd0, mis0}, 32'd0);
`endif
    tick(3);
    chk("redir_not_yet", {31'd0, valid0}, 32'd0);
    tick();
    chk("redir_inst_valid", {31'd0, valid0}, 32'd1);
    chk("redir_inst", inst0, 32'h1234_5678);
    chk("redir_pc", pc0, 32'h20);
    chk("redir_p4", p40, 32'h24);
    // misaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h23;
    tick();
    redirect = 1'b0;
    chk("mis_addr", addr0, 32'h20);
    chk("mis_valid", {31'd0, valid0}, 32'd0);
`ifdef INST_FETCH_MISALIGN_CHK_EN
    chk("mis_err_hi", {31'd0, mis0}, 32'd1);
`endif
    tick();
    chk("mis_addr1", addr0, 32'h21);
`ifdef INST_FETCH_MISALIGN_CHK_EN
    chk("mis_err_lo", {31'd0, mis0}, 32'd0);
`endif
    tick(3);
    chk("mis_inst", inst0, 32'h1234_5678);
    chk("mis_pc", pc0, 32'h20);
    // reset mid-fetch with a valid instruction pending
    ready = 1'b0;
    tick();
    chk("mid_addr", addr0, 32'h25);
    chk("mid_valid", {31'd0, valid0}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, valid0}, 32'd0);
    chk("mid_rst_addr", addr0, 32'h0);
    chk("mid_rst_inst", inst0, 32'h0);
    chk("mid_rst_pc", pc0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage of the MIPS pipeline. Drives the byte-wide, combinational-read instruction memory one byte address per cycle.
- Assembles four bytes big-endian into a 32-bit instruction and offers it to the IF/ID register through a valid/ready handshake.
- Owns the PC: sequential +4 advance, branch/jump redirect with flush, and a one-entry output buffer so fetching overlaps downstream stalls.

Parameters:
- PCL, 32, PC and memory address width.
- WORD, 8, memory data width; only 8 is supported (elaboration error otherwise).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  PCL  byte address to instruction memory; combinational = fetch_pc + byte_idx.
- mem_data  in  WORD  byte returned combinationally for mem_addr.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  PCL  target address for redirect.
- inst_out  out  32  assembled instruction.
- pc_out  out  PCL  address of inst_out.
- pc_plus4  out  PCL  pc_out + 4, wraps modulo 2^PCL.
- inst_valid  out  1  inst_out/pc_out hold a valid instruction.
- inst_ready  in  1  downstream accepts; low = pipeline stall.

Behaviour:
- Reset, checked every edge with priority over all else: fetch_pc <= RESET_PC, byte_idx <= 0, asm_reg <= 0, state <= FETCH, inst_valid <= 0, inst_out <= 0, pc_out <= 0.
- pc_plus4 is always combinational from pc_out, so it reads 4 after reset.
- States:
  - FETCH: each cycle, mem_data is latched into asm_reg byte lane (3 - byte_idx). Byte at fetch_pc goes to bits 31:24 (big-endian). byte_idx increments.
  - At byte_idx == 3, the instruction completes: {asm_reg[31:8], mem_data}.
  - HOLD: a completed instruction waits because the output buffer is full. mem_addr holds fetch_pc + 3 and no bytes are latched.
- Output buffer empty condition: !inst_valid || inst_ready.
- On completion (or in HOLD) with the buffer empty:
  - inst_out <= instruction, pc_out <= fetch_pc, inst_valid <= 1.
  - fetch_pc <= fetch_pc + 4 (wraps), byte_idx <= 0, state <= FETCH.
- On completion with the buffer full: go to HOLD with the completed word kept in asm_reg.
- Transfer occurs on a cycle with inst_valid && inst_ready. If nothing new loads that cycle, inst_valid <= 0. If a new instruction loads in the same cycle, inst_valid stays 1 and the contents are replaced.
- While inst_valid && !inst_ready, inst_out and pc_out are stable.
- Latency and throughput:
  - First instruction valid 4 cycles after rst deasserts.
  - Steady state is one instruction per 4 cycles.
  - Byte fetch continues during downstream stall until HOLD.
- Redirect has priority below rst and over everything else:
  - fetch_pc <= {redirect_pc[PCL-1:2], 2'b00}, byte_idx <= 0, state <= FETCH, inst_valid <= 0.
  - Any partial or held instruction is discarded.
  - A transfer in the redirect cycle is still honoured by downstream; the handshake is not retracted.
- Wrap: fetch_pc 32'hFFFF_FFFC + 4 -> 0. Byte addresses fc..ff are fetched normally.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds port misalign_err, out, 1.
  - misalign_err is a registered one-cycle pulse the cycle after a redirect with redirect_pc[1:0] != 0.
  - Reset value 0.
  - Fetch still uses the aligned address.
- Undefined: no port; low bits are cleared silently.

Decomposition:
- Shared package pipeline_pkg:
  - INST_W = 32, BYTES_PER_INST = 4.
  - Fetch state enum {FETCH, HOLD}.
  - Localparam NOP_INST = 32'h0000_0000 for benches.
- One natural sub-module, inst_byte_assembler: byte_idx counter, asm_reg, complete flag; clears on flush.
- PC, handshake and output buffer stay in the top module.

Test Plan:
- Memory bytes 00..07 = 8C,01,00,04,AC,02,00,08; rst 1 cycle, inst_ready=1 -> inst_valid first high in cycle 4 with inst_out=8C010004, pc_out=0, pc_plus4=4; 4 cycles later AC020008, pc_out=4.
- inst_ready=0 for 12 cycles after first valid -> inst_out held at 8C010004; unit reaches HOLD with mem_addr=7. On ready=1, second instruction appears the next cycle, then mem_addr=8.
- Redirect in the cycle byte_idx=2, redirect_pc=0x20 -> inst_valid=0 next cycle, mem_addr=0x20, first post-redirect instruction valid 4 cycles later with pc_out=0x20.
- Redirect with redirect_pc=0x23 -> fetch from 0x20. With INST_FETCH_MISALIGN_CHK_EN, misalign_err=1 for exactly one cycle; without it, the port is absent.
- rst asserted mid-fetch (byte_idx=1) with inst_valid=1 -> next cycle inst_valid=0, mem_addr=RESET_PC, inst_out=0.
- RESET_PC=32'hFFFF_FFFC -> instruction from bytes FC..FF; then mem_addr=0, pc_plus4 of the first instruction = 0.
